// File: rtl/neuro_ctrl_pkg.sv
// Shared types and encodings for the neuromorphic control sequencer.
package neuro_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_VLOAD  = 7'b0000010;
  localparam logic [6:0] OP_NEURO  = 7'b0110010;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  typedef struct packed {
    logic       branch;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic       wvr_write;
    logic       svr_write;
    logic       nsr_write;
    logic       nsr_write1;
    logic       nacc_vl;
    logic       sor_nacc;
    logic [1:0] aluop;
  } ctrl_bundle_t;

  typedef enum logic [0:0] {StIdle, StSeq} seq_state_e;

endpackage

// File: rtl/neuro_ctrl_decode.sv
// Combinational opcode/funct3 decoder producing the control bundle and vector flag.
module neuro_ctrl_decode
  import neuro_ctrl_pkg::*;
(
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  output ctrl_bundle_t ctrl,
  output logic         is_vector
);

  // Decode table; anything not listed stays at zero.
  always_comb begin
    ctrl      = '0;
    is_vector = 1'b0;
    unique case (opcode)
      OP_LOAD: begin
        ctrl.alusrc   = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      OP_STORE: begin
        ctrl.alusrc   = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      OP_RTYPE: begin
        if (funct3 == 3'b111) begin
          ctrl.nsr_write1 = 1'b1;
          ctrl.memtoreg   = 1'b1;
          ctrl.aluop      = ALUOP_ADD;
        end else begin
          ctrl.regwrite = 1'b1;
          ctrl.aluop    = ALUOP_R;
        end
      end
      OP_BRANCH: begin
        ctrl.branch = 1'b1;
        ctrl.aluop  = ALUOP_BR;
      end
      OP_ITYPE: begin
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      OP_VLOAD: begin
        ctrl.alusrc    = 1'b1;
        ctrl.memtoreg  = 1'b1;
        ctrl.wvr_write = (funct3 < 3'd3);
        ctrl.svr_write = (funct3 >= 3'd3) && (funct3 <= 3'd5);
        // funct3 6/7 is a single no-write micro-op
        is_vector      = (funct3 <= 3'd5);
      end
      OP_NEURO: begin
        ctrl.nsr_write = 1'b1;
        ctrl.sor_nacc  = (funct3 < 3'd4);
        ctrl.nacc_vl   = (funct3 == 3'b001);
        is_vector      = (funct3 == 3'b001);
      end
      default: begin
        ctrl      = '0;
        is_vector = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/neuro_ctrl_sequencer.sv
// Registered control sequencer: decodes, latches the bundle and expands vector ops per lane.
module neuro_ctrl_sequencer
  import neuro_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [LANE_W:0]   vl_in,
  input  logic              stall,
  input  logic              flush,
  output logic              ready_out,
  output logic              valid_out,
  output logic              branch,
  output logic              memtoreg,
  output logic              memwrite,
  output logic              alusrc,
  output logic              regwrite,
  output logic              wvr_write,
  output logic              svr_write,
  output logic              nsr_write,
  output logic              nsr_write1,
  output logic              nacc_vl,
  output logic              sor_nacc,
  output logic [1:0]        aluop,
  output logic [LANE_W-1:0] lane_idx,
  output logic              lane_last
);

  localparam logic [LANE_W:0]   NumLanesW = (LANE_W + 1)'(NUM_LANES);
  localparam logic [LANE_W-1:0] MaxIdx    = LANE_W'(NUM_LANES - 1);

  seq_state_e   state_q, state_d;
  ctrl_bundle_t bundle_q, bundle_d;
  logic         valid_q, valid_d;
  logic [LANE_W-1:0] lane_idx_q, lane_idx_d;
  logic              lane_last_q, lane_last_d;
  // Final lane index (L-1) of the instruction in flight
  logic [LANE_W-1:0] last_idx_q, last_idx_d;

  ctrl_bundle_t      dec_ctrl;
  logic              dec_is_vector;
  logic [LANE_W-1:0] new_last_idx;
  logic [LANE_W-1:0] lane_inc;
  logic              accept;

  neuro_ctrl_decode u_decode (
    .opcode    (opcode),
    .funct3    (funct3),
    .ctrl      (dec_ctrl),
    .is_vector (dec_is_vector)
  );

  assign accept   = valid_in & ready_out & ~stall & ~flush;
  assign lane_inc = lane_idx_q + LANE_W'(1);

  // Clamp the requested lane count and express it as the final lane index.
  always_comb begin
    if (!dec_is_vector || (vl_in == '0)) begin
      new_last_idx = '0;
    end else if (vl_in > NumLanesW) begin
      new_last_idx = MaxIdx;
    end else begin
      new_last_idx = LANE_W'(vl_in - 1'b1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: flush beats stall; a stall freezes the sequence.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StIdle;
    end else if (!stall) begin
      unique case (state_q)
        StIdle: if (accept && (new_last_idx != '0)) state_d = StSeq;
        StSeq:  if (lane_inc == last_idx_q) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM outputs: ready only while idle, which includes the cycle showing the final lane.
  always_comb begin
    ready_out = (state_q == StIdle);
  end

  // Next values of the output register and lane bookkeeping.
  always_comb begin
    valid_d     = valid_q;
    bundle_d    = bundle_q;
    lane_idx_d  = lane_idx_q;
    lane_last_d = lane_last_q;
    last_idx_d  = last_idx_q;
    if (flush) begin
      valid_d     = 1'b0;
      bundle_d    = '0;
      lane_idx_d  = '0;
      lane_last_d = 1'b0;
    end else if (!stall) begin
      if (state_q == StSeq) begin
        lane_idx_d  = lane_inc;
        lane_last_d = (lane_inc == last_idx_q);
      end else if (accept) begin
        valid_d     = 1'b1;
        bundle_d    = dec_ctrl;
        lane_idx_d  = '0;
        lane_last_d = (new_last_idx == '0);
        last_idx_d  = new_last_idx;
      end else begin
        // Bubble
        valid_d     = 1'b0;
        bundle_d    = '0;
        lane_idx_d  = '0;
        lane_last_d = 1'b0;
      end
    end
  end

  // Output and lane registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      bundle_q    <= '0;
      lane_idx_q  <= '0;
      lane_last_q <= 1'b0;
      last_idx_q  <= '0;
    end else begin
      valid_q     <= valid_d;
      bundle_q    <= bundle_d;
      lane_idx_q  <= lane_idx_d;
      lane_last_q <= lane_last_d;
      last_idx_q  <= last_idx_d;
    end
  end

  assign valid_out  = valid_q;
  assign branch     = bundle_q.branch;
  assign memtoreg   = bundle_q.memtoreg;
  assign memwrite   = bundle_q.memwrite;
  assign alusrc     = bundle_q.alusrc;
  assign regwrite   = bundle_q.regwrite;
  assign wvr_write  = bundle_q.wvr_write;
  assign svr_write  = bundle_q.svr_write;
  assign nsr_write  = bundle_q.nsr_write;
  assign nsr_write1 = bundle_q.nsr_write1;
  assign nacc_vl    = bundle_q.nacc_vl;
  assign sor_nacc   = bundle_q.sor_nacc;
  assign aluop      = bundle_q.aluop;
  assign lane_idx   = lane_idx_q;
  assign lane_last  = lane_last_q;

endmodule

// File: tb/tb_neuro_ctrl_sequencer.sv
// Scoreboard bench: a queue-based reference model predicts every displayed micro-op.
module tb_neuro_ctrl_sequencer;

  localparam int NL = 4;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          rst, valid_in, stall, flush;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [LW:0]   vl_in;
  logic          ready_out, valid_out;
  logic          branch, memtoreg, memwrite, alusrc, regwrite;
  logic          wvr_write, svr_write, nsr_write, nsr_write1, nacc_vl, sor_nacc;
  logic [1:0]    aluop;
  logic [LW-1:0] lane_idx;
  logic          lane_last;

  neuro_ctrl_sequencer #(.NUM_LANES(NL)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .opcode     (opcode),
    .funct3     (funct3),
    .vl_in      (vl_in),
    .stall      (stall),
    .flush      (flush),
    .ready_out  (ready_out),
    .valid_out  (valid_out),
    .branch     (branch),
    .memtoreg   (memtoreg),
    .memwrite   (memwrite),
    .alusrc     (alusrc),
    .regwrite   (regwrite),
    .wvr_write  (wvr_write),
    .svr_write  (svr_write),
    .nsr_write  (nsr_write),
    .nsr_write1 (nsr_write1),
    .nacc_vl    (nacc_vl),
    .sor_nacc   (sor_nacc),
    .aluop      (aluop),
    .lane_idx   (lane_idx),
    .lane_last  (lane_last)
  );

  always #5 clk = ~clk;

  // {valid, branch,memtoreg,memwrite,alusrc,regwrite,wvr,svr,nsr,nsr1,naccvl,sornacc,aluop, idx, last}
  typedef struct packed {
    logic          valid;
    logic [12:0]   ctrl;
    logic [LW-1:0] idx;
    logic          last;
  } obs_t;

  obs_t exp_q[$];
  obs_t held = '0;
  obs_t exp_now;
  obs_t got;
  logic adv = 1'b0;
  logic armed = 1'b0;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [12:0] ref_ctrl(input logic [6:0] op, input logic [2:0] f3);
    logic br, m2r, mw, as, rw, wv, sv, ns, ns1, nv, so;
    logic [1:0] al;
    br = 0; m2r = 0; mw = 0; as = 0; rw = 0; wv = 0; sv = 0; ns = 0; ns1 = 0; nv = 0; so = 0;
    al = 2'd0;
    case (op)
      7'b0000011: begin as = 1; m2r = 1; rw = 1; end
      7'b0100011: begin as = 1; mw = 1; end
      7'b0110011: if (f3 == 3'd7) begin ns1 = 1; m2r = 1; end else begin rw = 1; al = 2'd2; end
      7'b1100011: begin br = 1; al = 2'd1; end
      7'b0010011: begin as = 1; rw = 1; end
      7'b0000010: begin as = 1; m2r = 1; wv = (f3 < 3); sv = (f3 >= 3 && f3 <= 5); end
      7'b0110010: begin ns = 1; so = (f3 < 4); nv = (f3 == 1); end
      default: ;
    endcase
    return {br, m2r, mw, as, rw, wv, sv, ns, ns1, nv, so, al};
  endfunction

  function automatic int ref_lanes(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [LW:0] vl);
    bit vec;
    vec = (op == 7'b0000010 && f3 <= 5) || (op == 7'b0110010 && f3 == 1);
    if (!vec || vl == 0) return 1;
    if (int'(vl) > NL) return NL;
    return int'(vl);
  endfunction

  // Reference model: the queue holds micro-ops not yet displayed; empty queue == ready.
  always @(posedge clk) begin
    adv <= rst || flush || !stall;
    if (rst) armed <= 1'b1;
    if (rst || flush) begin
      exp_q.delete();
    end else if (!stall && exp_q.size() == 0 && valid_in) begin
      for (int k = 0; k < ref_lanes(opcode, funct3, vl_in); k++) begin
        exp_q.push_back('{valid: 1'b1, ctrl: ref_ctrl(opcode, funct3), idx: LW'(k),
                          last: (k == ref_lanes(opcode, funct3, vl_in) - 1)});
      end
    end
  end

  // Monitor: each advancing edge shows the next queued micro-op or a bubble; stalls hold.
  always @(negedge clk) begin
    if (armed) begin
      if (adv) begin
        if (exp_q.size() > 0) exp_now = exp_q.pop_front();
        else exp_now = '0;
        held = exp_now;
      end else begin
        exp_now = held;
      end
      got = '{valid: valid_out,
              ctrl: {branch, memtoreg, memwrite, alusrc, regwrite, wvr_write, svr_write,
                     nsr_write, nsr_write1, nacc_vl, sor_nacc, aluop},
              idx: lane_idx, last: lane_last};
      checks++;
      if (got !== exp_now) begin
        errors++;
        $display("FAIL %s @%0t: got valid=%b ctrl=%b idx=%0d last=%b, want valid=%b ctrl=%b idx=%0d last=%b",
                 adv ? "advance" : "hold", $time, got.valid, got.ctrl, got.idx, got.last,
                 exp_now.valid, exp_now.ctrl, exp_now.idx, exp_now.last);
      end
      checks++;
      if (ready_out !== (exp_q.size() == 0)) begin
        errors++;
        $display("FAIL ready_out @%0t: got %b want %b", $time, ready_out, exp_q.size() == 0);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Wait (bounded) until the model is ready, then present one instruction for one edge.
  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [LW:0] vl);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got busy after %0d cycles, want ready", n);
    end
    opcode = op; funct3 = f3; vl_in = vl; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask

  logic [6:0] ops [8];

  initial begin
    rst = 1'b1; valid_in = 0; stall = 0; flush = 0; opcode = 0; funct3 = 0; vl_in = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
    // Scalar stream
    send(7'b0000011, 3'd0, 3'd0);
    send(7'b0110011, 3'd0, 3'd0);
    send(7'b0110011, 3'd7, 3'd0);
    // Vector weight load, clamp, zero-length
    send(7'b0000010, 3'd1, 3'd3);
    send(7'b0000010, 3'd1, 3'd7);
    send(7'b0000010, 3'd4, 3'd0);
    send(7'b0000010, 3'd6, 3'd4);
    // Stall during lane 1
    send(7'b0000010, 3'd3, 3'd3);
    tick();
    stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
    tick(); tick();
    // Flush at lane 2, then back-to-back after a full sequence
    send(7'b0110010, 3'd1, 3'd4);
    tick();
    flush = 1'b1; stall = 1'b1;
    tick();
    flush = 1'b0; stall = 1'b0;
    send(7'b0110010, 3'd1, 3'd4);
    send(7'b0010011, 3'd2, 3'd0);
    send(7'b1100011, 3'd0, 3'd0);
    // Instruction dropped by a same-cycle flush
    opcode = 7'b0100011; valid_in = 1'b1; flush = 1'b1;
    tick();
    valid_in = 1'b0; flush = 1'b0;
    // Unknown opcode, then reset mid-sequence
    send(7'b1111111, 3'd5, 3'd2);
    send(7'b0110010, 3'd1, 3'd4);
    rst = 1'b1; stall = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    tick();
    // Randomized phase
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011,
            7'b0010011, 7'b0000010, 7'b0110010, 7'b1111111};
    for (int i = 0; i < 2000; i++) begin
      valid_in = ($urandom_range(0, 9) < 7);
      opcode   = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 7)];
      funct3   = 3'($urandom);
      vl_in    = 3'($urandom);
      stall    = ($urandom_range(0, 99) < 15);
      flush    = ($urandom_range(0, 99) < 5);
      rst      = ($urandom_range(0, 99) < 2);
      tick();
    end
    valid_in = 0; stall = 0; flush = 0; rst = 0;
    repeat (8) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
